// File: rtl/halflife_pkg.sv
// Shared definitions for the half-life decay sequencer and its datapath.
// Holds the controller state encoding and the default bus widths.
// Imported by the RTL and by the bench.
package halflife_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PERIOD_W = 8;
  localparam int DEF_HL_W     = 4;

endpackage

// File: rtl/halflife_prescaler.sv
// Down-counter that paces halvings: load sets the count, en counts down to zero.
// Latency: zero flag is registered state, valid the cycle after load.
// Backpressure: none; load has priority over en, and the count parks at zero.
module halflife_prescaler #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                en,
  output logic                zero
);

  logic [PERIOD_W-1:0] count;

  // Load wins; otherwise count down while enabled and not yet at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - PERIOD_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/halflife_sequencer.sv
// Sequences a decay run: loads a quantity, halves it every period, stops at threshold.
// Latency: start accepted on edge 0, k-th halving lands on edge k*max(period,1).
// Backpressure: start is only honoured in IDLE; abort forces IDLE from any state.
module halflife_sequencer
  import halflife_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int HL_W     = DEF_HL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    init_qty,
  input  logic [PERIOD_W-1:0] period,
  input  logic [WIDTH-1:0]    threshold,
  output logic [WIDTH-1:0]    qty,
  output logic [HL_W-1:0]     half_lives,
  output logic                busy,
  output logic                tick,
  output logic                done
);

  state_t              state;
  logic [WIDTH-1:0]    qty_q;
  logic [WIDTH-1:0]    thr_q;
  logic [PERIOD_W-1:0] per_q;
  logic [HL_W-1:0]     hl_q;
  logic                tick_q;

  logic                accept;
  logic                halve;
  logic                pre_zero;
  logic [PERIOD_W-1:0] reload_src;
  logic [PERIOD_W-1:0] reload_val;
  logic [WIDTH-1:0]    half_qty;

  // A period of 0 behaves like 1, so the reload value never underflows.
  assign reload_src = accept ? period : per_q;
  assign reload_val = (reload_src == '0) ? '0 : reload_src - PERIOD_W'(1);

  assign accept   = (state == IDLE) && start && !abort;
  assign halve    = (state == RUN) && pre_zero && !abort;
  assign half_qty = qty_q >> 1;

  halflife_prescaler #(
    .PERIOD_W (PERIOD_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || halve),
    .load_val (reload_val),
    .en       ((state == RUN) && !abort),
    .zero     (pre_zero)
  );

  // Controller FSM plus the quantity and half-life registers it owns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      qty_q  <= '0;
      thr_q  <= '0;
      per_q  <= '0;
      hl_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (abort) begin
        // Abort freezes qty and half_lives and suppresses any pending halving.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              qty_q <= init_qty;
              thr_q <= threshold;
              per_q <= period;
              hl_q  <= '0;
              state <= (init_qty <= threshold) ? DONE : RUN;
            end
          end
          RUN: begin
            if (pre_zero) begin
              qty_q  <= half_qty;
              hl_q   <= (hl_q == '1) ? hl_q : hl_q + HL_W'(1);
              tick_q <= 1'b1;
              if (half_qty <= thr_q) begin
                state <= DONE;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign qty        = qty_q;
  assign half_lives = hl_q;
  assign busy       = (state == RUN);
  assign tick       = tick_q;
  assign done       = (state == DONE);

endmodule

// File: tb/tb_halflife_sequencer.sv
// Bench for halflife_sequencer: directed test-plan runs plus randomized runs,
// each cycle compared against a closed-form model of the decay schedule.
// A second instance with a narrow half-life counter covers saturation.
module tb_halflife_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  init_qty;
  logic [7:0]  period;
  logic [7:0]  threshold;
  logic [7:0]  qty;
  logic [3:0]  half_lives;
  logic        busy;
  logic        tick;
  logic        done;

  logic        start_s;
  logic [15:0] init_s;
  logic [15:0] thr_s;
  logic [15:0] qty_s;
  logic [1:0]  hl_s;
  logic        busy_s;
  logic        tick_s;
  logic        done_s;

  int checks;
  int passes;
  int prev_q;
  int prev_hl;

  halflife_sequencer #(.WIDTH(8), .PERIOD_W(8), .HL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .init_qty   (init_qty),
    .period     (period),
    .threshold  (threshold),
    .qty        (qty),
    .half_lives (half_lives),
    .busy       (busy),
    .tick       (tick),
    .done       (done)
  );

  halflife_sequencer #(.WIDTH(16), .PERIOD_W(8), .HL_W(2)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .start      (start_s),
    .abort      (abort),
    .init_qty   (init_s),
    .period     (period),
    .threshold  (thr_s),
    .qty        (qty_s),
    .half_lives (hl_s),
    .busy       (busy_s),
    .tick       (tick_s),
    .done       (done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input int q, input int hl, input int b, input int t, input int d);
    return {9'b0, 16'(q), 4'(hl), 1'(b), 1'(t), 1'(d)};
  endfunction

  function automatic logic [31:0] observe(input int sel);
    if (sel == 1)
      return {9'b0, qty_s, 2'b0, hl_s, busy_s, tick_s, done_s};
    return {9'b0, 8'b0, qty, half_lives, busy, tick, done};
  endfunction

  task automatic check(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, obs, exp);
  endtask

  // One run: a = -1 no abort, a = 0 start+abort together, a >= 1 abort on edge a.
  task automatic run(input string tag, input int sel, input int init, input int per,
                     input int thr, input int a, input bit hold);
    int p, n, last, k, eq, ehl, eb, et, ed, hlmax, start_until;
    bit aborted;
    p = (per == 0) ? 1 : per;
    n = 0;
    while ((init >> n) > thr) n++;
    hlmax = (sel == 1) ? 3 : 15;
    aborted = (a == 0) || (a >= 1 && a <= n * p);
    last = aborted ? a + 2 : n * p + 2;
    start_until = hold ? (aborted ? a : n * p + 1) : 0;
    eq = prev_q;
    ehl = prev_hl;
    for (int e = 0; e <= last; e++) begin
      @(negedge clk);
      if (e == 0) begin
        init_qty  = 8'(init);
        threshold = 8'(thr);
        init_s    = 16'(init);
        thr_s     = 16'(thr);
        period    = 8'(per);
      end else begin
        init_qty  = 8'($urandom);
        threshold = 8'($urandom);
        init_s    = 16'($urandom);
        thr_s     = 16'($urandom);
        period    = 8'($urandom);
      end
      start   = (sel == 0) && (e <= start_until);
      start_s = (sel == 1) && (e <= start_until);
      abort   = (e == a);
      @(posedge clk);
      #1;
      eb = 0; et = 0; ed = 0;
      if (a == 0) begin
        eq = prev_q;
        ehl = prev_hl;
      end else begin
        if (aborted && e >= a) begin
          k = (a - 1) / p;
        end else begin
          k = (e / p < n) ? e / p : n;
          eb = (n > 0 && e < n * p) ? 1 : 0;
          et = (e > 0 && e % p == 0 && e / p <= n) ? 1 : 0;
          ed = (e == n * p) ? 1 : 0;
        end
        eq = init >> k;
        ehl = (k > hlmax) ? hlmax : k;
      end
      check(tag, e, observe(sel), pack(eq, ehl, eb, et, ed));
    end
    @(negedge clk);
    start = 1'b0;
    start_s = 1'b0;
    abort = 1'b0;
    if (sel == 0) begin
      prev_q = eq;
      prev_hl = ehl;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    prev_q = 0;
    prev_hl = 0;
    rst = 1'b0;
    start = 1'b0;
    start_s = 1'b0;
    abort = 1'b0;
    init_qty = '0;
    period = '0;
    threshold = '0;
    init_s = '0;
    thr_s = '0;
    #1;
    check("reset", 0, observe(0), pack(0, 0, 0, 0, 0));
    check("reset_s", 0, observe(1), pack(0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    // Directed runs from the test plan.
    run("basic", 0, 200, 3, 10, -1, 0);
    run("immediate", 0, 8, 5, 8, -1, 0);
    run("period0", 0, 16, 0, 0, -1, 0);
    run("period1", 0, 16, 1, 0, -1, 0);
    run("abort_run", 0, 200, 3, 10, 4, 0);
    run("start_abort_idle", 0, 77, 2, 3, 0, 0);
    run("start_held", 0, 200, 2, 10, -1, 1);
    run("saturate", 1, 65535, 1, 0, -1, 0);
    run("saturate_p2", 1, 40000, 2, 5, -1, 1);

    // Asynchronous reset between edges, in the middle of a run.
    @(negedge clk);
    init_qty = 8'd200; threshold = 8'd10; period = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 0, observe(0), pack(0, 0, 0, 0, 0));
    check("async_reset_s", 0, observe(1), pack(0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    prev_q = 0;
    prev_hl = 0;
    run("after_reset", 0, 200, 3, 10, -1, 0);

    // Randomized runs against the closed-form schedule.
    for (int r = 0; r < 24; r++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      if (r % 6 == 5)
        run("rand_s", 1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 300)), -1, 1'($urandom_range(0, 1)));
      else
        run("rand", 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 40)), a, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
